// File: rtl/adder_tree_scheduler.sv
// adder_tree_scheduler: round-robin time-sharing of one pipelined adder tree among NUM_REQ requesters.
// Define ADDER_TREE_SCHED_STATS_EN to add saturating stat_issued/stat_stalled counters.
module adder_tree_scheduler #(
    parameter int DATAWIDTH       = 4,
    parameter int NUM_INPUTS      = 16,
    parameter int NUM_REQ         = 4,
    parameter int TREE_LATENCY    = 1,
    parameter int MAX_OUTSTANDING = 8,
    localparam int SUM_W = DATAWIDTH + $clog2(NUM_INPUTS - 1) + 2,
    localparam int ID_W  = $clog2(NUM_REQ),
    localparam int VEC_W = NUM_INPUTS * DATAWIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*VEC_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     tree_valid,
    output logic [VEC_W-1:0]         tree_data,
    input  logic                     tree_ovalid,
    input  logic [SUM_W-1:0]         tree_sum,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [SUM_W-1:0]         rsp_sum,
    output logic [7:0]               outstanding,
    output logic                     idle,
    output logic                     err_tag
`ifdef ADDER_TREE_SCHED_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_stalled
`endif
);
    localparam logic [7:0]      MAX_OUT = 8'(MAX_OUTSTANDING);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   NREQ    = (ID_W + 1)'(NUM_REQ);

    logic [ID_W-1:0]                  ptr_q, ptr_d, win;
    logic [ID_W:0]                    cand;
    logic                             found, credit_ok, grant, ret;
    logic                             tree_valid_q, tree_valid_d;
    logic [VEC_W-1:0]                 tree_data_q, tree_data_d;
    logic [TREE_LATENCY:0]            tag_v_q, tag_v_d;
    logic [TREE_LATENCY:0][ID_W-1:0]  tag_id_q, tag_id_d;
    logic                             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]                  rsp_id_q, rsp_id_d;
    logic [SUM_W-1:0]                 rsp_sum_q, rsp_sum_d;
    logic [7:0]                       outstanding_q, outstanding_d;
    logic                             err_tag_q, err_tag_d;

    always_comb begin
        found = 1'b0;
        win = '0;
        cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W + 1)'(k);
            cand = cand >= NREQ ? cand - NREQ : cand;
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                win = cand[ID_W-1:0];
            end
        end
    end

    // Tag pipe is one stage longer than the tree: the extra stage covers the issue register.
    always_comb begin
        credit_ok = outstanding_q < MAX_OUT;
        grant = en && !rst && credit_ok && found;
        ret = tree_ovalid && outstanding_q != 8'd0;
        req_ready = grant ? NUM_REQ'(1) << win : '0;
        ptr_d = grant ? (win == LAST_ID ? '0 : win + 1'b1) : ptr_q;
        tree_valid_d = grant;
        tree_data_d = grant ? req_data[win*VEC_W +: VEC_W] : tree_data_q;
        tag_v_d = {tag_v_q[TREE_LATENCY-1:0], grant};
        tag_id_d = {tag_id_q[TREE_LATENCY-1:0], win};
        rsp_valid_d = tree_ovalid;
        rsp_id_d = tree_ovalid ? tag_id_q[TREE_LATENCY] : rsp_id_q;
        rsp_sum_d = tree_ovalid ? tree_sum : rsp_sum_q;
        err_tag_d = err_tag_q | (tag_v_q[TREE_LATENCY] != tree_ovalid);
        outstanding_d = grant && !ret ? outstanding_q + 8'd1 :
                        !grant && ret ? outstanding_q - 8'd1 : outstanding_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            tree_valid_q <= 1'b0;
            tree_data_q <= '0;
            tag_v_q <= '0;
            tag_id_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q <= '0;
            rsp_sum_q <= '0;
            outstanding_q <= '0;
            err_tag_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            tree_valid_q <= tree_valid_d;
            tree_data_q <= tree_data_d;
            tag_v_q <= tag_v_d;
            tag_id_q <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q <= rsp_id_d;
            rsp_sum_q <= rsp_sum_d;
            outstanding_q <= outstanding_d;
            err_tag_q <= err_tag_d;
        end
    end

    assign tree_valid  = tree_valid_q;
    assign tree_data   = tree_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_sum     = rsp_sum_q;
    assign outstanding = outstanding_q;
    assign idle        = outstanding_q == 8'd0 && !grant;
    assign err_tag     = err_tag_q;

`ifdef ADDER_TREE_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d, stat_stalled_q, stat_stalled_d;

    always_comb begin
        stat_issued_d = grant && stat_issued_q != '1 ? stat_issued_q + 32'd1 : stat_issued_q;
        stat_stalled_d = |req_valid && en && !credit_ok && stat_stalled_q != '1 ?
                         stat_stalled_q + 32'd1 : stat_stalled_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_stalled_q <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stalled_q <= stat_stalled_d;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_stalled = stat_stalled_q;
`endif
endmodule
